qed_dup_generator: RTL and testbench

- Instruction-side half of the EDDI-V QED scheme; sits between IFU buffer 0 and the decoder.
- In ORIGINAL mode it forwards fetched instructions unchanged and records a register-remapped copy of each in a FIFO. Registers 0-15 map to 16-31.
- In CHECK mode it stalls the IFU and replays the recorded copies to the decoder.
- Its outputs (qed_ifu_instruction, mode, vld_inst) are the signals the QED consistency checker monitors.

---
 rtl/qed_dup_generator.sv | 205 ++++++++++++++++++++
 tb/tb_qed_dup_generator.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_dup_generator.sv
// qed_dup_generator
//   Instruction-side duplicator for EDDI-V QED. Sits between IFU buffer 0 and
//   the decoder. In ORIGINAL mode, fetched instructions pass through to the
//   decoder, and a register-remapped copy of each one is recorded in a FIFO.
//   The remap moves registers 0-15 to 16-31. In CHECK mode the IFU is stalled
//   and the recorded copies are replayed to the decoder in recording order.
//
// Ports
//   clk, rst             core clock, synchronous active-high reset
//   ena                  QED enable; 0 = pure pass-through, FIFO cleared
//   ifu_inst, ifu_vld    instruction from IFU buffer 0 and its valid
//   exec_dup             request to replay the recorded copies (CHECK mode)
//   dec_rdy              decoder takes the output register this cycle
//   ifu_stall            IFU must hold ifu_inst/ifu_vld
//   qed_ifu_instruction  registered instruction to the decoder
//   vld_inst             qed_ifu_instruction is valid
//   mode                 0 = original, 1 = replayed duplicate
//   dup_count            FIFO occupancy
//   illegal_inst         one-cycle pulse: accepted original used a reg >= 16
module qed_dup_generator #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IW    = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [IW-1:0]              ifu_inst,
    input  logic                       ifu_vld,
    input  logic                       exec_dup,
    input  logic                       dec_rdy,
    output logic                       ifu_stall,
    output logic [IW-1:0]              qed_ifu_instruction,
    output logic                       vld_inst,
    output logic                       mode,
    output logic [$clog2(DEPTH+1)-1:0] dup_count,
    output logic                       illegal_inst
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [31:0]   NopInst = 32'h0100_0000;
    localparam logic [PW-1:0] PtrOne  = PW'(1);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    typedef enum logic {StOrig, StCheck} state_e;

    // Builds the duplicate of an original. Bits above 31 are sideband and are
    // never touched. Control transfers cannot be replayed, so they become NOPs.
    function automatic logic [IW-1:0] remap(input logic [IW-1:0] x);
        logic [IW-1:0] r;
        r = x;
        if (x[31:0] != NopInst) begin
            case (x[31:30])
                2'b00: begin
                    if (x[24:22] == 3'b100) begin
                        r[29] = 1'b1;            // SETHI: rd only
                    end else begin
                        r[31:0] = NopInst;       // branches
                    end
                end
                2'b01:   r[31:0] = NopInst;      // CALL
                default: begin
                    r[29] = 1'b1;                // rd
                    r[18] = 1'b1;                // rs1
                    if (!x[13]) begin
                        r[4] = 1'b1;             // rs2, register form only
                    end
                end
            endcase
        end
        return r;
    endfunction

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   out_q, out_d;
    logic            vld_q, vld_d;
    logic            mode_q, mode_d;
    logic            illegal_q, illegal_d;
    logic [IW-1:0]   mem_q [DEPTH];

    logic            push;
    logic            accept;
    logic            inst_illegal;
    logic [CW-1:0]   count_next;
    logic [IW-1:0]   push_data;

    // An original that already uses the upper register half would collide
    // with its own duplicate.
    assign inst_illegal = ifu_inst[31] &&
                          (ifu_inst[29] || ifu_inst[18] || (!ifu_inst[13] && ifu_inst[4]));
    assign push_data    = remap(ifu_inst);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        vld_d      = vld_q;
        mode_d     = mode_q;
        illegal_d  = 1'b0;
        push       = 1'b0;
        accept     = 1'b0;
        count_next = count_q;
        ifu_stall  = 1'b0;

        if (!ena) begin
            // Pass-through; any recorded or in-flight replay is dropped.
            ifu_stall = !dec_rdy;
            state_d   = StOrig;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            if (dec_rdy) begin
                vld_d = ifu_vld;
                if (ifu_vld) begin
                    out_d  = ifu_inst;
                    mode_d = 1'b0;
                end
            end
        end else begin
            case (state_q)
                StOrig: begin
                    ifu_stall = !dec_rdy || (count_q == CntFull);
                    if (dec_rdy) begin
                        accept = ifu_vld && (count_q != CntFull);
                        vld_d  = accept;
                        if (accept) begin
                            mode_d = 1'b0;
                            if (inst_illegal) begin
                                illegal_d = 1'b1;
                                out_d     = {ifu_inst[IW-1:32], NopInst};
                            end else begin
                                out_d      = ifu_inst;
                                push       = 1'b1;
                                wr_ptr_d   = wr_ptr_q + PtrOne;
                                count_next = count_q + CntOne;
                            end
                        end
                        count_d = count_next;
                        // Same-cycle accept and exec_dup: the push is counted first.
                        if ((exec_dup || (count_next == CntFull)) && (count_next != '0)) begin
                            state_d = StCheck;
                        end
                    end
                end
                StCheck: begin
                    ifu_stall = 1'b1;
                    if (dec_rdy) begin
                        out_d    = mem_q[rd_ptr_q];
                        vld_d    = 1'b1;
                        mode_d   = 1'b1;
                        rd_ptr_d = rd_ptr_q + PtrOne;
                        count_d  = count_q - CntOne;
                        if (count_q == CntOne) begin
                            state_d = StOrig;
                        end
                    end
                end
                default: state_d = StOrig;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StOrig;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_q     <= '0;
            vld_q     <= 1'b0;
            mode_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_q     <= out_d;
            vld_q     <= vld_d;
            mode_q    <= mode_d;
            illegal_q <= illegal_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign qed_ifu_instruction = out_q;
    assign vld_inst            = vld_q;
    assign mode                = mode_q;
    assign dup_count           = count_q;
    assign illegal_inst        = illegal_q;

endmodule

// File: tb/tb_qed_dup_generator.sv
module tb_qed_dup_generator;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [32:0] ifu_inst;
    logic        ifu_vld;
    logic        exec_dup;
    logic        dec_rdy;
    logic        ifu_stall;
    logic [32:0] qed_ifu_instruction;
    logic        vld_inst;
    logic        mode;
    logic [4:0]  dup_count;
    logic        illegal_inst;

    int n_tests = 0;
    int n_fail  = 0;

    qed_dup_generator #(
        .DEPTH(DEPTH),
        .IW   (33)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ena                (ena),
        .ifu_inst           (ifu_inst),
        .ifu_vld            (ifu_vld),
        .exec_dup           (exec_dup),
        .dec_rdy            (dec_rdy),
        .ifu_stall          (ifu_stall),
        .qed_ifu_instruction(qed_ifu_instruction),
        .vld_inst           (vld_inst),
        .mode               (mode),
        .dup_count          (dup_count),
        .illegal_inst       (illegal_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (field-level view) ----------------
    function automatic logic [32:0] model_r(input logic [32:0] x);
        logic [1:0]  op;
        logic [2:0]  op2;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        imm;
        logic [32:0] y;
        op  = x[31:30];
        op2 = x[24:22];
        rd  = x[29:25];
        rs1 = x[18:14];
        rs2 = x[4:0];
        imm = x[13];
        y   = x;
        if (x[31:0] == NOP) return x;
        if (op == 2'd0 && op2 == 3'd4) begin
            y[29:25] = rd + ((rd < 16) ? 5'd16 : 5'd0);
            return y;
        end
        if (op < 2'd2) return {x[32], NOP};
        y[29:25] = rd + ((rd < 16) ? 5'd16 : 5'd0);
        y[18:14] = rs1 + ((rs1 < 16) ? 5'd16 : 5'd0);
        if (imm == 1'b0) y[4:0] = rs2 + ((rs2 < 16) ? 5'd16 : 5'd0);
        return y;
    endfunction

    function automatic bit model_illegal(input logic [32:0] x);
        int rd;
        int rs1;
        int rs2;
        rd  = int'(x[29:25]);
        rs1 = int'(x[18:14]);
        rs2 = int'(x[4:0]);
        if (x[31:30] < 2'd2) return 1'b0;
        return (rd >= 16) || (rs1 >= 16) || (x[13] == 1'b0 && rs2 >= 16);
    endfunction

    logic [32:0] m_q[$];
    bit          m_check = 1'b0;
    bit          m_live  = 1'b0;
    logic [32:0] m_out   = '0;
    bit          m_vld   = 1'b0;
    bit          m_mode  = 1'b0;
    bit          m_ill   = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_check = 1'b0;
                m_out   = '0;
                m_vld   = 1'b0;
                m_mode  = 1'b0;
                m_ill   = 1'b0;
                m_live  = 1'b1;
            end else if (!ena) begin
                m_q.delete();
                m_check = 1'b0;
                m_ill   = 1'b0;
                if (dec_rdy) begin
                    m_vld = ifu_vld;
                    if (ifu_vld) begin
                        m_out  = ifu_inst;
                        m_mode = 1'b0;
                    end
                end
            end else if (!m_check) begin
                m_ill = 1'b0;
                if (dec_rdy) begin
                    m_vld = ifu_vld && (m_q.size() < DEPTH);
                    if (m_vld) begin
                        m_mode = 1'b0;
                        if (model_illegal(ifu_inst)) begin
                            m_out = {ifu_inst[32], NOP};
                            m_ill = 1'b1;
                        end else begin
                            m_out = ifu_inst;
                            m_q.push_back(model_r(ifu_inst));
                        end
                    end
                    if ((exec_dup || m_q.size() == DEPTH) && m_q.size() > 0) m_check = 1'b1;
                end
            end else begin
                m_ill = 1'b0;
                if (dec_rdy) begin
                    m_out  = m_q.pop_front();
                    m_vld  = 1'b1;
                    m_mode = 1'b1;
                    if (m_q.size() == 0) m_check = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                bit exp_stall;
                if (!ena)         exp_stall = !dec_rdy;
                else if (m_check) exp_stall = 1'b1;
                else              exp_stall = !dec_rdy || (m_q.size() == DEPTH);
                chk("cyc_ifu_stall", 64'(ifu_stall), 64'(exp_stall));
                chk("cyc_vld_inst", 64'(vld_inst), 64'(m_vld));
                chk("cyc_dup_count", 64'(dup_count), 64'(m_q.size()));
                chk("cyc_illegal_inst", 64'(illegal_inst), 64'(m_ill));
                if (m_vld) begin
                    chk("cyc_out", 64'(qed_ifu_instruction), 64'(m_out));
                    chk("cyc_mode", 64'(mode), 64'(m_mode));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Legal ALU op: rd=k%16, rs1=(k+1)%16, rs2=(k+2)%16, sideband bit = k[0].
    function automatic logic [32:0] mk_alu(input int k);
        logic [31:0] kk;
        kk = k;
        return {kk[0], 2'b10, 1'b0, kk[3:0], 6'b0, 1'b0, 4'((k + 1) % 16),
                1'b0, 8'b0, 1'b0, 4'((k + 2) % 16)};
    endfunction

    logic [32:0] exp2 [3] = '{33'h023000000, 33'h001000000, 33'h001000000};

    initial begin
        rst      = 1'b1;
        ena      = 1'b1;
        dec_rdy  = 1'b1;
        ifu_vld  = 1'b0;
        exec_dup = 1'b0;
        ifu_inst = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_vld", 64'(vld_inst), 64'd0);
        chk("rst_mode", 64'(mode), 64'd0);
        chk("rst_dup_count", 64'(dup_count), 64'd0);
        chk("rst_illegal", 64'(illegal_inst), 64'd0);
        chk("rst_out", 64'(qed_ifu_instruction), 64'd0);
        #1 chk("rst_stall", 64'(ifu_stall), 64'd0);

        // ADD %g1,%g2,%g3 then exec_dup
        ifu_inst = 33'h086004002;
        ifu_vld  = 1'b1;
        tick();
        ifu_vld  = 1'b0;
        exec_dup = 1'b1;
        chk("add_out", 64'(qed_ifu_instruction), 64'h086004002);
        chk("add_mode", 64'(mode), 64'd0);
        chk("add_dup_count", 64'(dup_count), 64'd1);
        tick();
        exec_dup = 1'b0;
        #1 chk("add_check_stall", 64'(ifu_stall), 64'd1);
        tick();
        chk("add_dup_out", 64'(qed_ifu_instruction), 64'h0A6044012);
        chk("add_dup_mode", 64'(mode), 64'd1);
        chk("add_dup_count0", 64'(dup_count), 64'd0);
        #1 chk("add_stall_released", 64'(ifu_stall), 64'd0);
        tick();
        chk("add_vld_drop", 64'(vld_inst), 64'd0);

        // SETHI, NOP, BA then exec_dup
        ifu_vld  = 1'b1;
        ifu_inst = 33'h003000000;
        tick();
        ifu_inst = 33'h001000000;
        tick();
        ifu_inst = 33'h010800000;
        tick();
        ifu_vld  = 1'b0;
        exec_dup = 1'b1;
        chk("seq_dup_count", 64'(dup_count), 64'd3);
        tick();
        exec_dup = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("seq_replay_out", 64'(qed_ifu_instruction), 64'(exp2[j]));
            chk("seq_replay_mode", 64'(mode), 64'd1);
        end
        tick();
        chk("seq_back_orig_vld", 64'(vld_inst), 64'd0);

        // Fill to DEPTH without exec_dup
        ifu_vld = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            ifu_inst = mk_alu(k);
            if (k == DEPTH - 1) begin
                #1 chk("full_stall_before", 64'(ifu_stall), 64'd0);
            end
            tick();
        end
        ifu_inst = mk_alu(DEPTH);
        chk("full_dup_count", 64'(dup_count), 64'(DEPTH));
        #1 chk("full_stall", 64'(ifu_stall), 64'd1);
        tick();
        chk("full_first_replay", 64'(qed_ifu_instruction), 64'h0A0044012);
        chk("full_first_mode", 64'(mode), 64'd1);
        chk("full_count_dec", 64'(dup_count), 64'(DEPTH - 1));
        for (int k = 1; k < DEPTH; k++) tick();
        ifu_vld = 1'b0;
        chk("full_drained", 64'(dup_count), 64'd0);
        tick();

        // Illegal original OR %l0,%g1,%g2
        ifu_vld  = 1'b1;
        ifu_inst = mk_alu(3);
        tick();
        ifu_inst = 33'h084140001;
        tick();
        ifu_vld = 1'b0;
        chk("ill_out", 64'(qed_ifu_instruction), 64'h001000000);
        chk("ill_mode", 64'(mode), 64'd0);
        chk("ill_pulse", 64'(illegal_inst), 64'd1);
        chk("ill_dup_count", 64'(dup_count), 64'd1);
        tick();
        chk("ill_pulse_end", 64'(illegal_inst), 64'd0);
        exec_dup = 1'b1;
        tick();
        exec_dup = 1'b0;
        tick();
        chk("ill_drain", 64'(dup_count), 64'd0);
        tick();

        // dec_rdy low mid-replay
        ifu_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ifu_inst = mk_alu(k + 4);
            tick();
        end
        ifu_vld  = 1'b0;
        exec_dup = 1'b1;
        tick();
        exec_dup = 1'b0;
        tick();
        dec_rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("hold_out", 64'(qed_ifu_instruction), 64'h0A8054016);
            chk("hold_mode", 64'(mode), 64'd1);
            chk("hold_dup_count", 64'(dup_count), 64'd3);
        end
        #1 chk("hold_stall", 64'(ifu_stall), 64'd1);
        dec_rdy = 1'b1;
        for (int j = 0; j < 3; j++) tick();
        chk("hold_drained", 64'(dup_count), 64'd0);
        tick();

        // Reset with five entries pending in CHECK
        ifu_vld = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ifu_inst = mk_alu(k + 8);
            tick();
        end
        ifu_vld  = 1'b0;
        exec_dup = 1'b1;
        tick();
        exec_dup = 1'b0;
        tick();
        chk("rst5_pre_count", 64'(dup_count), 64'd5);
        rst     = 1'b1;
        dec_rdy = 1'b0;
        tick();
        chk("rst5_vld", 64'(vld_inst), 64'd0);
        chk("rst5_mode", 64'(mode), 64'd0);
        chk("rst5_dup_count", 64'(dup_count), 64'd0);
        #1 chk("rst5_stall_rdy0", 64'(ifu_stall), 64'd1);
        dec_rdy = 1'b1;
        #1 chk("rst5_stall_rdy1", 64'(ifu_stall), 64'd0);
        rst      = 1'b0;
        exec_dup = 1'b1;
        tick();
        exec_dup = 1'b0;
        chk("rst5_exec_ignored_vld", 64'(vld_inst), 64'd0);
        #1 chk("rst5_exec_ignored_stall", 64'(ifu_stall), 64'd0);
        tick();

        // ena dropped during CHECK aborts the replay
        ifu_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ifu_inst = mk_alu(k + 20);
            tick();
        end
        ifu_vld  = 1'b0;
        exec_dup = 1'b1;
        tick();
        exec_dup = 1'b0;
        tick();
        ena      = 1'b0;
        ifu_vld  = 1'b1;
        ifu_inst = 33'h084140001;
        tick();
        chk("ena0_out", 64'(qed_ifu_instruction), 64'h084140001);
        chk("ena0_mode", 64'(mode), 64'd0);
        chk("ena0_illegal", 64'(illegal_inst), 64'd0);
        chk("ena0_dup_count", 64'(dup_count), 64'd0);
        #1 chk("ena0_stall", 64'(ifu_stall), 64'd0);
        ifu_vld = 1'b0;
        ena     = 1'b1;
        tick();
        exec_dup = 1'b1;
        tick();
        exec_dup = 1'b0;
        chk("ena1_exec_ignored", 64'(dup_count), 64'd0);
        chk("ena1_vld", 64'(vld_inst), 64'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
